pc_stack: RTL and testbench
===========================

# pc_stack

Hardware return-address stack for the PIC16C5x core, sitting directly upstream of the program counter. It captures the return address on CALL and presents the top entry to the PC for RETLW. It reproduces the 16C5x two-level shift-stack semantics: the oldest entry is lost on overflow, and the bottom entry is duplicated on underflow. Depth and error reporting are parameterised and observable for debug.

## Interface
Parameters:
- `PC_WIDTH`, default `` `PC_WIDTH `` (9): width of a stored return address.
- `DEPTH`, default 2: number of stack entries; must be ≥ 2.
- `LVL_WIDTH`, default 2: width of `level`; must satisfy 2^LVL_WIDTH > DEPTH.

Ports:
- `clk` — in — 1 — core clock; all state updates on the rising edge.
- `rst` — in — 1 — synchronous, active-high reset.
- `push` — in — 1 — one-cycle strobe; driven during `EX_Q4_CALL`.
- `pushData` — in — PC_WIDTH — return address, i.e. the already-incremented PC.
- `pop` — in — 1 — one-cycle strobe; driven during `EX_Q4_RETLW`.
- `clrErr` — in — 1 — clears the sticky error flags.
- `stackOut` — out — PC_WIDTH — top entry (entry 0), driven straight from the register; this feeds the PC's `stackIn`.
- `level` — out — LVL_WIDTH — number of valid entries, 0..DEPTH.
- `empty` — out — 1 — `level == 0`.
- `full` — out — 1 — `level == DEPTH`.
- `overflow` — out — 1 — sticky; set when a push occurs at full.
- `underflow` — out — 1 — sticky; set when a pop occurs at empty.

## Operation
- **Storage.** DEPTH registers, `entry[0]` (top) through `entry[DEPTH-1]` (bottom). No read/write pointers: the stack is a pure shift register.
- **Push only.**
  - `entry[0] <= pushData`.
  - `entry[i] <= entry[i-1]` for i ≥ 1; the old bottom entry is discarded.
  - `level <= min(level+1, DEPTH)`.
  - If `full` was set before the edge, `overflow <= 1`.
- **Pop only.**
  - `entry[i] <= entry[i+1]` for i < DEPTH-1.
  - `entry[DEPTH-1]` holds its value, so the bottom entry is duplicated.
  - `level <= level-1`, saturating at 0.
  - If `empty` was set before the edge, `underflow <= 1`; stack contents still shift.
- **Push and pop in the same cycle.** `entry[0] <= pushData`, all other entries and `level` unchanged, no error flagged. The ISA cannot produce this case; it is defined for robustness.
- **Neither asserted.** All state holds.
- **`clrErr`.** Clears `overflow` and `underflow` on the next edge. If a new error event occurs in the same cycle, setting wins.
- **Output logic.** `empty`, `full` and `stackOut` are combinational from registered state only; there is no combinational path from any input to any output.

## Timing
- **Reset values** (applied when `rst` = 1 at the edge):
  - all entries = 0, so `stackOut` = 0.
  - `level` = 0, `empty` = 1, `full` = 0.
  - `overflow` = 0, `underflow` = 0.
- **Reset priority.** `rst` overrides `push`, `pop` and `clrErr` in the same cycle. Reset mid-sequence discards all entries with no error flagged.
- **Pop latency.** 0 cycles for the read: the PC samples `stackOut` on the same edge at which `pop` is sampled (`EX_Q4_RETLW`). The stack shifts on that same edge. The new top is visible one cycle after `pop`.
- **Push latency.** 1 cycle: `pushData` sampled with `push` appears on `stackOut` the next cycle.
- **Back-to-back operation.** Push/pop strobes on consecutive cycles are supported; each edge is independent. The core's minimum spacing is one instruction cycle (4 clocks).
- **Strobe width.** A strobe held high N cycles performs N operations. Callers must pulse for exactly one clock.

## Test plan
Defaults: DEPTH=2, PC_WIDTH=9.

1. **Reset.** Assert `rst` with `push`=1, `pushData`=0x1AB → `stackOut`=0, `level`=0, `empty`=1, both error flags 0.
2. **Push/pop order.**
   - Push 0x010, then push 0x020 → `stackOut`=0x020, `level`=2, `full`=1.
   - Pop → `stackOut`=0x010, `level`=1.
   - Pop → `stackOut`=0x010 (duplicated bottom), `level`=0, `empty`=1, `underflow`=0.
3. **Overflow.**
   - Push 0x011, 0x022, 0x033 → `stackOut`=0x033, `level`=2, `overflow`=1.
   - Pop → `stackOut`=0x022.
   - Pop → `stackOut`=0x022; 0x011 is lost.
4. **Underflow and sticky clear.**
   - Pop from empty → `underflow`=1, `level`=0.
   - Pulse `clrErr` → `underflow`=0 next cycle.
   - `clrErr` coincident with a pop at empty → `underflow` stays 1.
5. **Simultaneous push+pop.** At `level`=1 with top=0x040, `push`=`pop`=1, `pushData`=0x0FF → `stackOut`=0x0FF, `level`=1, no flags.
6. **Integration with the PC.** Connect to PC, run CALL 0x05 from address 0x003, then RETLW → PC reloads 0x004, and the stack returns to `level`=0.

Source files
------------

// File: rtl/pc_stack.sv
// Two-level-style return-address shift stack for the PIC16C5x core.
// Entry 0 feeds the PC directly; the oldest entry is lost on overflow.
`ifndef PC_WIDTH
`define PC_WIDTH 9
`endif

module pc_stack #(
    parameter int PC_WIDTH  = `PC_WIDTH,
    parameter int DEPTH     = 2,
    parameter int LVL_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [PC_WIDTH-1:0]  pushData,
    input  logic                 pop,
    input  logic                 clrErr,
    output logic [PC_WIDTH-1:0]  stackOut,
    output logic [LVL_WIDTH-1:0] level,
    output logic                 empty,
    output logic                 full,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [LVL_WIDTH-1:0] LVL_MAX = LVL_WIDTH'(DEPTH);

    logic [PC_WIDTH-1:0]  entry_q [DEPTH];
    logic [PC_WIDTH-1:0]  entry_d [DEPTH];
    logic [LVL_WIDTH-1:0] level_q;
    logic [LVL_WIDTH-1:0] level_d;
    logic                 ovf_q;
    logic                 ovf_d;
    logic                 unf_q;
    logic                 unf_d;
    logic                 empty_w;
    logic                 full_w;

    assign empty_w = (level_q == '0);
    assign full_w  = (level_q == LVL_MAX);

    always_comb begin
        entry_d = entry_q;
        level_d = level_q;
        ovf_d   = clrErr ? 1'b0 : ovf_q;
        unf_d   = clrErr ? 1'b0 : unf_q;
        if (push && pop) begin
            // Replace the top in place; depth and flags are untouched.
            entry_d[0] = pushData;
        end else if (push) begin
            entry_d[0] = pushData;
            for (int i = 1; i < DEPTH; i++) begin
                entry_d[i] = entry_q[i-1];
            end
            if (full_w) begin
                ovf_d = 1'b1;
            end else begin
                level_d = level_q + 1'b1;
            end
        end else if (pop) begin
            // Bottom entry holds, so it is duplicated upward.
            for (int i = 0; i < DEPTH-1; i++) begin
                entry_d[i] = entry_q[i+1];
            end
            if (empty_w) begin
                unf_d = 1'b1;
            end else begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            entry_q <= entry_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign stackOut  = entry_q[0];
    assign level     = level_q;
    assign empty     = empty_w;
    assign full      = full_w;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed testbench for pc_stack (DEPTH=2, PC_WIDTH=9).
// Each scenario task drives strobes and checks results inline.
module tb_pc_stack;

    logic       clk;
    logic       rst;
    logic       push;
    logic [8:0] pushData;
    logic       pop;
    logic       clrErr;
    logic [8:0] stackOut;
    logic [1:0] level;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       underflow;

    int tests;
    int fails;

    pc_stack #(.PC_WIDTH(9), .DEPTH(2), .LVL_WIDTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pushData (pushData),
        .pop      (pop),
        .clrErr   (clrErr),
        .stackOut (stackOut),
        .level    (level),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply the currently driven strobes for one edge, then release them.
    task automatic tick();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        clrErr   = 1'b0;
        pushData = '0;
    endtask

    task automatic do_push(input logic [8:0] d);
        push = 1'b1;
        pushData = d;
        tick();
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        push = 1'b1;
        pushData = 9'h1AB;
        tick();
        tests++;
        if (stackOut !== 9'h000) begin
            fails++;
            $display("FAIL reset_stackOut got %h exp 000", stackOut);
        end
        tests++;
        if (level !== 2'd0 || empty !== 1'b1 || full !== 1'b0) begin
            fails++;
            $display("FAIL reset_level got lvl=%0d e=%b f=%b exp 0 1 0",
                     level, empty, full);
        end
        tests++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags got o=%b u=%b exp 0 0",
                     overflow, underflow);
        end
    endtask

    task automatic test_push_pop();
        do_push(9'h010);
        tests++;
        if (stackOut !== 9'h010 || level !== 2'd1) begin
            fails++;
            $display("FAIL push1 got %h lvl=%0d exp 010 1", stackOut, level);
        end
        do_push(9'h020);
        tests++;
        if (stackOut !== 9'h020 || level !== 2'd2 || full !== 1'b1) begin
            fails++;
            $display("FAIL push2 got %h lvl=%0d f=%b exp 020 2 1",
                     stackOut, level, full);
        end
        do_pop();
        tests++;
        if (stackOut !== 9'h010 || level !== 2'd1 || full !== 1'b0) begin
            fails++;
            $display("FAIL pop1 got %h lvl=%0d f=%b exp 010 1 0",
                     stackOut, level, full);
        end
        do_pop();
        tests++;
        if (stackOut !== 9'h010 || level !== 2'd0 || empty !== 1'b1
            || underflow !== 1'b0) begin
            fails++;
            $display("FAIL pop2 got %h lvl=%0d e=%b u=%b exp 010 0 1 0",
                     stackOut, level, empty, underflow);
        end
    endtask

    task automatic test_overflow();
        do_push(9'h011);
        do_push(9'h022);
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_early got %b exp 0", overflow);
        end
        do_push(9'h033);
        tests++;
        if (stackOut !== 9'h033 || level !== 2'd2 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_push got %h lvl=%0d o=%b exp 033 2 1",
                     stackOut, level, overflow);
        end
        do_pop();
        tests++;
        if (stackOut !== 9'h022 || level !== 2'd1) begin
            fails++;
            $display("FAIL ovf_pop1 got %h lvl=%0d exp 022 1", stackOut, level);
        end
        do_pop();
        tests++;
        if (stackOut !== 9'h022 || level !== 2'd0 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_pop2 got %h lvl=%0d o=%b exp 022 0 1",
                     stackOut, level, overflow);
        end
    endtask

    task automatic test_underflow();
        do_pop();
        tests++;
        if (underflow !== 1'b1 || level !== 2'd0) begin
            fails++;
            $display("FAIL unf_set got u=%b lvl=%0d exp 1 0", underflow, level);
        end
        clrErr = 1'b1;
        tick();
        tests++;
        if (underflow !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL clr got u=%b o=%b exp 0 0", underflow, overflow);
        end
        clrErr = 1'b1;
        pop = 1'b1;
        tick();
        tests++;
        if (underflow !== 1'b1 || level !== 2'd0) begin
            fails++;
            $display("FAIL clr_vs_set got u=%b lvl=%0d exp 1 0",
                     underflow, level);
        end
        tests++;
        if (stackOut !== 9'h022) begin
            fails++;
            $display("FAIL unf_data got %h exp 022", stackOut);
        end
    endtask

    task automatic test_push_and_pop();
        clrErr = 1'b1;
        tick();
        do_push(9'h040);
        tests++;
        if (stackOut !== 9'h040 || level !== 2'd1) begin
            fails++;
            $display("FAIL pp_setup got %h lvl=%0d exp 040 1", stackOut, level);
        end
        push = 1'b1;
        pop = 1'b1;
        pushData = 9'h0FF;
        tick();
        tests++;
        if (stackOut !== 9'h0FF || level !== 2'd1
            || overflow !== 1'b0 || underflow !== 1'b0) begin
            fails++;
            $display("FAIL pp got %h lvl=%0d o=%b u=%b exp 0ff 1 0 0",
                     stackOut, level, overflow, underflow);
        end
        do_pop();
        tests++;
        if (stackOut !== 9'h022 || level !== 2'd0) begin
            fails++;
            $display("FAIL pp_below got %h lvl=%0d exp 022 0", stackOut, level);
        end
    endtask

    task automatic test_back_to_back();
        do_push(9'h101);
        do_push(9'h102);
        do_pop();
        do_push(9'h103);
        tests++;
        if (stackOut !== 9'h103 || level !== 2'd2 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL b2b got %h lvl=%0d o=%b exp 103 2 0",
                     stackOut, level, overflow);
        end
        // Two-cycle strobe performs two pops.
        pop = 1'b1;
        @(posedge clk);
        #1;
        tick();
        tests++;
        if (stackOut !== 9'h101 || level !== 2'd0 || underflow !== 1'b0) begin
            fails++;
            $display("FAIL wide_pop got %h lvl=%0d u=%b exp 101 0 0",
                     stackOut, level, underflow);
        end
    endtask

    task automatic test_pc_integration();
        logic [8:0] pc;
        pc = 9'h003;
        // CALL 0x05 at 0x003 pushes the incremented PC.
        do_push(pc + 9'h001);
        pc = 9'h005;
        tests++;
        if (stackOut !== 9'h004 || level !== 2'd1) begin
            fails++;
            $display("FAIL call got %h lvl=%0d exp 004 1", stackOut, level);
        end
        pop = 1'b1;
        @(posedge clk);
        pc = stackOut;
        #1;
        pop = 1'b0;
        tests++;
        if (pc !== 9'h004 || level !== 2'd0 || empty !== 1'b1) begin
            fails++;
            $display("FAIL retlw got pc=%h lvl=%0d e=%b exp 004 0 1",
                     pc, level, empty);
        end
    endtask

    task automatic test_reset_midseq();
        do_push(9'h0AA);
        do_push(9'h0BB);
        do_push(9'h0CC);
        rst = 1'b1;
        pop = 1'b1;
        clrErr = 1'b0;
        tick();
        tests++;
        if (stackOut !== 9'h000 || level !== 2'd0 || overflow !== 1'b0
            || underflow !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid got %h lvl=%0d o=%b u=%b exp 000 0 0 0",
                     stackOut, level, overflow, underflow);
        end
        do_pop();
        tests++;
        if (stackOut !== 9'h000 || underflow !== 1'b1) begin
            fails++;
            $display("FAIL rst_cleared got %h u=%b exp 000 1",
                     stackOut, underflow);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        clrErr = 1'b0;
        pushData = '0;
        #2;
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_push_and_pop();
        test_back_to_back();
        test_pc_integration();
        test_reset_midseq();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
